// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the RV32I multi-cycle core:
// states, opcodes, write-back selects and fault codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_BOOT        = 3'd0,
        S_FETCH_INSTR = 3'd1,
        S_FETCH_REGS  = 3'd2,
        S_EXECUTE     = 3'd3,
        S_LOAD        = 3'd4,
        S_STORE       = 3'd5,
        S_HALT        = 3'd6,
        S_FAULT       = 3'd7
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUIMM = 7'b0010011;
    localparam logic [6:0] OP_ALUREG = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        RD_ALU  = 2'd0,
        RD_PC4  = 2'd1,
        RD_LOAD = 2'd2,
        RD_UIMM = 2'd3
    } rd_sel_t;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'b00,
        FLT_FETCH   = 2'b01,
        FLT_DATA    = 2'b10,
        FLT_ILLEGAL = 2'b11
    } fault_t;

    // Timeout counter must hold WAIT_TIMEOUT; a disabled timer still needs 1 bit.
    function automatic int timer_w(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait-state counter: counts un-acked request cycles and
// flags the cycle in which the access would exceed WAIT_TIMEOUT.
module ctrl_wait_timer
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int W = timer_w(WAIT_TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

    generate
        if (WAIT_TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam logic [W-1:0] LIMIT = W'(WAIT_TIMEOUT - 1);
            assign expired = inc && (count == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core.
// Define CTRL_PERF_COUNTERS_EN to add cycle/instret counter outputs.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       instr_we,
    output logic       regs_we,
    output logic       rd_we,
    output logic [1:0] rd_sel,
    output logic       pc_we,
    output logic [2:0] state,
    output logic       halted,
    output logic [1:0] fault
`ifdef CTRL_PERF_COUNTERS_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);

    state_t     st;
    state_t     st_nxt;
    logic [1:0] fault_nxt;
    logic       wait_inc;
    logic       to_exp;

    logic is_alu, is_jump, is_upper, is_branch;
    logic is_load, is_store, is_system;

    assign is_alu    = (opcode == OP_ALUREG) || (opcode == OP_ALUIMM);
    assign is_jump   = (opcode == OP_JAL)    || (opcode == OP_JALR);
    assign is_upper  = (opcode == OP_LUI)    || (opcode == OP_AUIPC);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_system = (opcode == OP_SYSTEM);

    // Counter runs only while a request is outstanding; any other cycle clears it.
    assign wait_inc = mem_req && !mem_ready;

    ctrl_wait_timer #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!wait_inc),
        .inc     (wait_inc),
        .expired (to_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= S_BOOT;
            fault <= FLT_NONE;
        end else begin
            st    <= st_nxt;
            fault <= fault_nxt;
        end
    end

    assign state = st;

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        instr_we     = 1'b0;
        regs_we      = 1'b0;
        rd_we        = 1'b0;
        rd_sel       = RD_ALU;
        pc_we        = 1'b0;
        halted       = 1'b0;
        st_nxt       = st;
        fault_nxt    = fault;
        case (st)
            S_BOOT: st_nxt = S_FETCH_INSTR;
            S_FETCH_INSTR: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    instr_we = 1'b1;
                    st_nxt   = S_FETCH_REGS;
                end else if (to_exp) begin
                    st_nxt    = S_FAULT;
                    fault_nxt = FLT_FETCH;
                end
            end
            S_FETCH_REGS: begin
                regs_we = 1'b1;
                st_nxt  = S_EXECUTE;
            end
            S_EXECUTE: begin
                unique case (1'b1)
                    is_alu: begin
                        rd_we  = 1'b1;
                        pc_we  = 1'b1;
                        st_nxt = S_FETCH_INSTR;
                    end
                    is_jump: begin
                        rd_we  = 1'b1;
                        rd_sel = RD_PC4;
                        pc_we  = 1'b1;
                        st_nxt = S_FETCH_INSTR;
                    end
                    is_upper: begin
                        rd_we  = 1'b1;
                        rd_sel = RD_UIMM;
                        pc_we  = 1'b1;
                        st_nxt = S_FETCH_INSTR;
                    end
                    is_branch: begin
                        pc_we  = 1'b1;
                        st_nxt = S_FETCH_INSTR;
                    end
                    is_load:   st_nxt = S_LOAD;
                    is_store:  st_nxt = S_STORE;
                    is_system: st_nxt = S_HALT;
                    default: begin
                        st_nxt    = S_FAULT;
                        fault_nxt = FLT_ILLEGAL;
                    end
                endcase
            end
            S_LOAD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) begin
                    rd_we  = 1'b1;
                    rd_sel = RD_LOAD;
                    pc_we  = 1'b1;
                    st_nxt = S_FETCH_INSTR;
                end else if (to_exp) begin
                    st_nxt    = S_FAULT;
                    fault_nxt = FLT_DATA;
                end
            end
            S_STORE: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = 1'b1;
                if (mem_ready) begin
                    pc_we  = 1'b1;
                    st_nxt = S_FETCH_INSTR;
                end else if (to_exp) begin
                    st_nxt    = S_FAULT;
                    fault_nxt = FLT_DATA;
                end
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: halted = 1'b1;
        endcase
    end

`ifdef CTRL_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (st != S_BOOT && st != S_HALT && st != S_FAULT)
                cycle_count <= cycle_count + 32'd1;
            if (pc_we)
                instret_count <= instret_count + 32'd1;
        end
    end
`endif

endmodule
